otter_mem_arbiter: RTL
======================

Name: otter_mem_arbiter

Overview:
- Arbitrates the single data port (port 2) of the OTTER byte-addressed memory between two requesters: the pipeline MEM stage and the serial programmer.
- Sequences each access: one-cycle writes, two-cycle reads matching the memory's synchronous read latency.
- Stalls the pipeline while the CPU access is pending.
- Sits between the MEM-stage pipeline register, the programmer and the memory's data port.

Parameters:
MAX_WAIT, 4, cycles a pending CPU request may lose to the programmer before the CPU is forced to win (legal 1..255)
STAT_W, 16, width of statistics counters (used only with OTTER_ARB_STATS_EN)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
cpu_req  in  1  MEM stage requests access; held stable until completion
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_din  in  32  store data
cpu_size  in  2  00 byte, 01 half, 10 word
cpu_sign  in  1  1 = unsigned load (funct3[2])
cpu_rdata  out  32  load data, valid with cpu_valid
cpu_valid  out  1  CPU access completes this cycle
cpu_stall  out  1  hold IF/DE/EX/MEM pipeline registers
prog_req  in  1  programmer word-write request; held until prog_ack
prog_addr  in  32  byte address
prog_din  in  32  write data
prog_ack  out  1  programmer write completes this cycle
mem_addr  out  32  to memory ADDR2
mem_din  out  32  to memory DIN2
mem_we  out  1  to memory WRITE2
mem_re  out  1  to memory READ2
mem_size  out  2  to memory SIZE
mem_sign  out  1  to memory SIGN
mem_dout  in  32  from memory DOUT2, valid one cycle after mem_re
stat_cpu_grants  out  STAT_W  CPU grants (optional feature)
stat_stall_cycles  out  STAT_W  cycles with cpu_stall=1 (optional feature)

Behaviour:
- Reset (asynchronous, any state, including mid-read): state to IDLE; wait_cnt and stat counters cleared; all outputs 0. Reset during CPU_RD discards the read; no cpu_valid is produced.
- States:
  - IDLE: grant decided combinationally this cycle.
  - CPU_RD: memory read in flight.
- Arbitration in IDLE:
  - prog_req only: programmer granted.
  - cpu_req only: CPU granted.
  - Both asserted: programmer wins unless wait_cnt == MAX_WAIT, in which case the CPU wins.
- wait_cnt:
  - Increments each IDLE cycle in which cpu_req=1 and the CPU is not granted, saturating at MAX_WAIT.
  - Clears on CPU grant.
  - Holds when cpu_req=0.
- Programmer grant: mem_addr=prog_addr, mem_din=prog_din, mem_we=1, mem_re=0, mem_size=10, mem_sign=0; prog_ack=1 the same cycle; remain in IDLE.
- CPU write grant: drive cpu_addr/din/size/sign with mem_we=1; cpu_valid=1 and cpu_stall=0 the same cycle; remain in IDLE.
- CPU read grant:
  - Grant cycle: drive address/size/sign with mem_re=1, cpu_stall=1, then go to CPU_RD.
  - CPU_RD: cpu_rdata=mem_dout, cpu_valid=1, cpu_stall=0; no new grant issued; mem_we=mem_re=0; return to IDLE.
  - Back-to-back loads therefore take 2 cycles each.
- cpu_stall=1 whenever cpu_req=1 and cpu_valid=0 this cycle. cpu_stall is always 0 when cpu_req=0.
- No grant: mem_we=mem_re=0, mem_addr/din/size/sign=0, cpu_rdata=0.
- prog_req is ignored in CPU_RD; it is serviced from IDLE on the next cycle.
- cpu_valid and prog_ack are never both 1 in the same cycle.
- mem_we and mem_re are never both 1.

Optional Feature:
OTTER_ARB_STATS_EN:
- Defined:
  - stat_cpu_grants increments on each CPU grant.
  - stat_stall_cycles increments on each cycle with cpu_stall=1.
  - Both wrap modulo 2^STAT_W and clear on RESET.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset mid-read: CPU load at 0x100, assert RESET in the CPU_RD cycle -> cpu_valid stays 0; all outputs 0; state IDLE after release.
- CPU store, programmer idle: cpu_req=1, cpu_we=1, addr 0x200, din 0xDEADBEEF, size 10 -> same cycle mem_we=1, mem_addr=0x200, cpu_valid=1, cpu_stall=0.
- CPU load: addr 0x204, memory returns 0x12345678 -> cycle 0 mem_re=1, cpu_stall=1; cycle 1 cpu_valid=1, cpu_rdata=0x12345678, cpu_stall=0.
- Contention, MAX_WAIT=4: prog_req and cpu_req (store) held continuously -> prog_ack on cycles 0-3, CPU granted on cycle 4 (cpu_valid=1, wait_cnt cleared), programmer granted on cycle 5.
- Programmer during CPU read: prog_req rises in the CPU_RD cycle -> prog_ack=0 that cycle, prog_ack=1 next cycle with mem_size=10, mem_we=1.
- With OTTER_ARB_STATS_EN: three CPU loads with no contention -> stat_cpu_grants=3, stat_stall_cycles=3.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// Arbitrates OTTER memory data port 2 between the MEM stage and the serial programmer.
// Writes complete in the grant cycle and loads complete one cycle later. The CPU is stalled while its access is pending.
// Optional statistics counters are enabled with OTTER_ARB_STATS_EN.
module otter_mem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int STAT_W   = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_din,
   input  logic [1:0]        cpu_size,
   input  logic              cpu_sign,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_valid,
   output logic              cpu_stall,
   input  logic              prog_req,
   input  logic [31:0]       prog_addr,
   input  logic [31:0]       prog_din,
   output logic              prog_ack,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_we,
   output logic              mem_re,
   output logic [1:0]        mem_size,
   output logic              mem_sign,
   input  logic [31:0]       mem_dout,
   output logic [STAT_W-1:0] stat_cpu_grants,
   output logic [STAT_W-1:0] stat_stall_cycles
);

   typedef enum logic {IDLE, CPU_RD} state_t;

   localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       cpu_gnt, prog_gnt;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Outputs are gated by RESET so that a reset landing mid-read drops the read.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      prog_gnt     = 1'b0;
      cpu_gnt      = 1'b0;
      mem_addr     = '0;
      mem_din      = '0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_size     = 2'b00;
      mem_sign     = 1'b0;
      cpu_rdata    = '0;
      cpu_valid    = 1'b0;
      prog_ack     = 1'b0;
      if (!RESET) begin
         case (state)
            IDLE: begin
               prog_gnt = prog_req && !(cpu_req && (wait_cnt == WAIT_LIM));
               cpu_gnt  = cpu_req && !prog_gnt;
               if (prog_gnt) begin
                  mem_addr = prog_addr;
                  mem_din  = prog_din;
                  mem_we   = 1'b1;
                  mem_size = 2'b10;
                  prog_ack = 1'b1;
               end else if (cpu_gnt) begin
                  mem_addr = cpu_addr;
                  mem_size = cpu_size;
                  mem_sign = cpu_sign;
                  if (cpu_we) begin
                     mem_din   = cpu_din;
                     mem_we    = 1'b1;
                     cpu_valid = 1'b1;
                  end else begin
                     mem_re    = 1'b1;
                     state_nxt = CPU_RD;
                  end
               end
               if (cpu_gnt)
                  wait_cnt_nxt = '0;
               else if (cpu_req && (wait_cnt < WAIT_LIM))
                  wait_cnt_nxt = wait_cnt + 8'd1;
            end
            CPU_RD: begin
               cpu_rdata = mem_dout;
               cpu_valid = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign cpu_stall = !RESET && cpu_req && !cpu_valid;

`ifdef OTTER_ARB_STATS_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stat_cpu_grants   <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (cpu_gnt)
            stat_cpu_grants <= stat_cpu_grants + 1'b1;
         if (cpu_stall)
            stat_stall_cycles <= stat_stall_cycles + 1'b1;
      end
   end
`else
   assign stat_cpu_grants   = '0;
   assign stat_stall_cycles = '0;
`endif

endmodule
